// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared types and constants for the DVP test-pattern transmitter
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } dvp_state_e;

    localparam logic [1:0] MODE_BARS    = 2'd0;
    localparam logic [1:0] MODE_RAMP    = 2'd1;
    localparam logic [1:0] MODE_SOLID   = 2'd2;
    localparam logic [1:0] MODE_CHECKER = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// rtl/dvp_pattern_gen.sv - combinational RGB565 pixel generator for the test patterns
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 176
) (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic [7:0]  frame_i,
    input  logic [1:0]  mode_i,
    output logic [15:0] pix_o
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] bar_idx;
    logic        unused_bits;

    assign unused_bits = ^{y_i[15:6], frame_i[7:5], bar_idx[15:3]};

    always_comb begin
        bar_idx = x_i / 16'(BAR_W);
        pix_o   = 16'h0000;
        case (mode_i)
            MODE_BARS:  pix_o = bar_colour(bar_idx[2:0]);
            MODE_RAMP:  pix_o = {x_i[4:0], y_i[5:0], frame_i[4:0]};
            MODE_SOLID: pix_o = {frame_i[4:0], 6'h00, ~frame_i[4:0]};
            default:    pix_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// rtl/dvp_pattern_tx.sv - DVP camera-side transmitter emitting RGB565 test frames
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = 176,
    parameter int V_ACTIVE = 144,
    parameter int H_BLANK  = 32,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_FRONT  = 10
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEnable,
    input  logic [1:0] iMode,
    output logic       oPCLK,
    output logic       oVSYNC,
    output logic       oHREF,
    output logic [7:0] oDATA,
    output logic       oFrame_Start,
    output logic [7:0] oFrame_Count
);

    localparam int LINE = 2 * H_ACTIVE + H_BLANK;
    localparam int SXW  = $clog2(LINE);
    localparam int LYW  = $clog2(VS_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

    localparam logic [SXW-1:0] SX_LAST   = SXW'(LINE - 1);
    localparam logic [SXW-1:0] SX_ACTIVE = SXW'(2 * H_ACTIVE);

    dvp_state_e     state_q, state_d;
    logic           ph_q;
    logic [SXW-1:0] sx_q, sx_d;
    logic [LYW-1:0] ly_q, ly_d, ly_last;
    logic [1:0]     mode_q, mode_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           vsync_q, vsync_d, href_q, href_d, start_q, start_d;
    logic [7:0]     data_q, data_d;
    logic [15:0]    pix;

    always_comb begin
        case (state_q)
            ST_VSYNC:  ly_last = LYW'(VS_LINES - 1);
            ST_VBACK:  ly_last = LYW'(V_BACK - 1);
            ST_ACTIVE: ly_last = LYW'(V_ACTIVE - 1);
            default:   ly_last = LYW'(V_FRONT - 1);
        endcase
    end

    // Everything advances only on the edge that ends a slot (ph high), so all
    // bus signals change together with the falling edge of oPCLK.
    always_comb begin
        state_d = state_q;
        sx_d    = sx_q;
        ly_d    = ly_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        if (ph_q) begin
            if (state_q == ST_IDLE) begin
                if (iEnable) begin
                    state_d = ST_VSYNC;
                    start_d = 1'b1;
                    mode_d  = iMode;
                end
            end else if (sx_q != SX_LAST) begin
                sx_d = sx_q + SXW'(1);
            end else begin
                sx_d = '0;
                ly_d = (ly_q == ly_last) ? '0 : ly_q + LYW'(1);
                if (ly_q == ly_last) begin
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        default: begin
                            cnt_d = cnt_q + 8'd1;
                            if (iEnable) begin
                                state_d = ST_VSYNC;
                                start_d = 1'b1;
                                mode_d  = iMode;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end

    dvp_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_gen (
        .x_i     (16'(sx_d >> 1)),
        .y_i     (16'(ly_d)),
        .frame_i (cnt_d),
        .mode_i  (mode_d),
        .pix_o   (pix)
    );

    always_comb begin
        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE) && (sx_d < SX_ACTIVE);
        data_d  = 8'h00;
        if (href_d) data_d = sx_d[0] ? pix[7:0] : pix[15:8];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            ph_q    <= 1'b0;
            state_q <= ST_IDLE;
            sx_q    <= '0;
            ly_q    <= '0;
            mode_q  <= MODE_BARS;
            cnt_q   <= 8'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
        end else begin
            ph_q    <= ~ph_q;
            state_q <= state_d;
            sx_q    <= sx_d;
            ly_q    <= ly_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            data_q  <= data_d;
            start_q <= start_d;
        end
    end

    assign oPCLK        = ph_q;
    assign oVSYNC       = vsync_q;
    assign oHREF        = href_q;
    assign oDATA        = data_q;
    assign oFrame_Start = start_q;
    assign oFrame_Count = cnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb/tb_dvp_pattern_tx.sv - self-checking bench for dvp_pattern_tx on a small frame geometry
module tb_dvp_pattern_tx;

    localparam int H_A = 8;
    localparam int V_A = 4;
    localparam int H_B = 4;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iEnable = 1'b0;
    logic [1:0] iMode = 2'd0;
    logic       oPCLK, oVSYNC, oHREF, oFrame_Start;
    logic [7:0] oDATA, oFrame_Count;

    int checks = 0;
    int errors = 0;
    logic       sb_en = 1'b0;
    logic [7:0] sb_q[$];

    dvp_pattern_tx #(
        .H_ACTIVE(H_A), .V_ACTIVE(V_A), .H_BLANK(H_B),
        .VS_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iEnable(iEnable), .iMode(iMode),
        .oPCLK(oPCLK), .oVSYNC(oVSYNC), .oHREF(oHREF), .oDATA(oDATA),
        .oFrame_Start(oFrame_Start), .oFrame_Count(oFrame_Count)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [15:0] exp_pix(input int mode, input int x, input int y, input int f);
        int bar;
        bar = x / (H_A / 8);
        case (mode)
            0: begin
                case (bar)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1: return 16'(((x % 32) << 11) | ((y % 64) << 5) | (f % 32));
            2: return 16'(((f % 32) << 11) | (31 - (f % 32)));
            default: return ((((x / 8) ^ (y / 8)) % 2) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic push_frame(input int mode, input int f);
        logic [15:0] p;
        for (int y = 0; y < V_A; y++)
            for (int x = 0; x < H_A; x++) begin
                p = exp_pix(mode, x, y, f);
                sb_q.push_back(p[15:8]);
                sb_q.push_back(p[7:0]);
            end
    endtask

    // Receiver: one sample per PCLK rising, taken half an iCLK later.
    always @(negedge iCLK) begin
        if (sb_en && oPCLK) begin
            checks++;
            if (oHREF) begin
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_byte: got %02h, no byte required", oDATA);
                end else begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    if (oDATA !== e) begin
                        errors++;
                        $display("FAIL sb_byte: got %02h, required %02h", oDATA, e);
                    end
                end
            end else if (oDATA !== 8'h00) begin
                errors++;
                $display("FAIL sb_blank_data: got %02h, required 00", oDATA);
            end
        end
    end

    task automatic do_reset();
        iRST_N = 1'b0;
        iEnable = 1'b0;
        iMode = 2'd0;
        sb_en = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
    endtask

    task automatic test_reset();
        int bad_tog, bad_idle;
        logic prev;
        iRST_N = 1'b0;
        iEnable = 1'b0;
        repeat (4) @(negedge iCLK);
        checks++; if (oPCLK !== 1'b0) begin errors++; $display("FAIL reset_pclk: got %b, required 0", oPCLK); end
        checks++; if (oVSYNC !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b, required 0", oVSYNC); end
        checks++; if (oHREF !== 1'b0) begin errors++; $display("FAIL reset_href: got %b, required 0", oHREF); end
        checks++; if (oDATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, required 00", oDATA); end
        checks++; if (oFrame_Start !== 1'b0) begin errors++; $display("FAIL reset_fstart: got %b, required 0", oFrame_Start); end
        checks++; if (oFrame_Count !== 8'd0) begin errors++; $display("FAIL reset_fcount: got %0d, required 0", oFrame_Count); end
        iRST_N = 1'b1;
        prev = 1'b0;
        bad_tog = 0;
        bad_idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge iCLK);
            if (oPCLK === prev) bad_tog++;
            if (oVSYNC !== 1'b0 || oHREF !== 1'b0 || oDATA !== 8'h00) bad_idle++;
            prev = oPCLK;
        end
        checks++; if (bad_tog != 0) begin errors++; $display("FAIL idle_pclk_toggle: %0d non-toggling cycles, required 0", bad_tog); end
        checks++; if (bad_idle != 0) begin errors++; $display("FAIL idle_outputs: %0d active cycles, required 0", bad_idle); end
    endtask

    task automatic test_line_structure();
        int lat, vs_len, pulses, hi_cnt, lo_cnt, bad_hi, bad_lo;
        logic prev_h;
        do_reset();
        iEnable = 1'b1;
        lat = 0;
        for (int i = 0; i < 6 && oVSYNC !== 1'b1; i++) begin
            @(negedge iCLK);
            lat++;
        end
        checks++; if (oVSYNC !== 1'b1 || lat > 3) begin errors++; $display("FAIL enable_latency: got %0d iCLK (vsync=%b), required <= 3", lat, oVSYNC); end
        vs_len = 0;
        for (int i = 0; i < 100 && oVSYNC === 1'b1; i++) begin
            vs_len++;
            @(negedge iCLK);
        end
        checks++; if (vs_len != 40) begin errors++; $display("FAIL vsync_length: got %0d iCLK, required 40", vs_len); end
        pulses = 0; hi_cnt = 0; lo_cnt = 0; bad_hi = 0; bad_lo = 0; prev_h = 1'b0;
        for (int i = 0; i < 400 && oFrame_Start !== 1'b1; i++) begin
            @(negedge iCLK);
            if (oPCLK === 1'b1) begin
                if (oHREF === 1'b1) begin
                    if (!prev_h) begin
                        if (pulses > 0 && lo_cnt != H_B) bad_lo++;
                        pulses++;
                        hi_cnt = 0;
                    end
                    hi_cnt++;
                end else begin
                    if (prev_h) begin
                        if (hi_cnt != 2 * H_A) bad_hi++;
                        lo_cnt = 0;
                    end
                    lo_cnt++;
                end
                prev_h = oHREF;
            end
        end
        iEnable = 1'b0;
        checks++; if (pulses != V_A) begin errors++; $display("FAIL href_pulses: got %0d, required %0d", pulses, V_A); end
        checks++; if (bad_hi != 0) begin errors++; $display("FAIL href_high_len: %0d bad lines, required 0", bad_hi); end
        checks++; if (bad_lo != 0) begin errors++; $display("FAIL href_low_len: %0d bad gaps, required 0", bad_lo); end
    endtask

    task automatic test_color_bars();
        do_reset();
        push_frame(0, 0);
        sb_en = 1'b1;
        iEnable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge iCLK);
            if (oFrame_Start === 1'b1) iEnable = 1'b0;
        end
        sb_en = 1'b0;
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bars_missing: %0d bytes not seen, required 0", sb_q.size()); end
        checks++; if (oFrame_Count !== 8'd1) begin errors++; $display("FAIL bars_fcount: got %0d, required 1", oFrame_Count); end
    endtask

    task automatic test_frame_solid();
        int fs;
        do_reset();
        iMode = 2'd2;
        push_frame(2, 0);
        push_frame(2, 1);
        sb_en = 1'b1;
        iEnable = 1'b1;
        fs = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge iCLK);
            if (oFrame_Start === 1'b1) begin
                fs++;
                if (fs == 2) iEnable = 1'b0;
            end
        end
        sb_en = 1'b0;
        checks++; if (fs != 2) begin errors++; $display("FAIL solid_fstart: got %0d pulse cycles, required 2", fs); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL solid_missing: %0d bytes not seen, required 0", sb_q.size()); end
        checks++; if (oFrame_Count !== 8'd2) begin errors++; $display("FAIL solid_fcount: got %0d, required 2", oFrame_Count); end
    endtask

    task automatic test_mode_latch();
        int fs;
        logic seen;
        do_reset();
        iMode = 2'd0;
        push_frame(0, 0);
        push_frame(3, 1);
        sb_en = 1'b1;
        iEnable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge iCLK);
            if (oHREF === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL latch_href_timeout: got no HREF, required HREF within 300 iCLK"); end
        repeat (60) @(negedge iCLK);
        iMode = 2'd3;
        fs = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge iCLK);
            if (oFrame_Start === 1'b1) begin
                fs++;
                iEnable = 1'b0;
            end
        end
        sb_en = 1'b0;
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL latch_missing: %0d bytes not seen, required 0", sb_q.size()); end
        checks++; if (fs != 1) begin errors++; $display("FAIL latch_fstart: got %0d, required 1", fs); end
        checks++; if (oFrame_Count !== 8'd2) begin errors++; $display("FAIL latch_fcount: got %0d, required 2", oFrame_Count); end
    endtask

    task automatic test_enable_drop();
        int pulses, more, vs, fs;
        logic prev_h;
        do_reset();
        iMode = 2'd1;
        push_frame(1, 0);
        sb_en = 1'b1;
        iEnable = 1'b1;
        pulses = 0;
        prev_h = 1'b0;
        for (int i = 0; i < 400 && pulses < 3; i++) begin
            @(negedge iCLK);
            if (oHREF === 1'b1 && !prev_h) pulses++;
            prev_h = oHREF;
        end
        iEnable = 1'b0;
        checks++; if (pulses != 3) begin errors++; $display("FAIL drop_href_timeout: got %0d lines, required 3", pulses); end
        more = 0; vs = 0; fs = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge iCLK);
            if (oHREF === 1'b1 && !prev_h) more++;
            if (oVSYNC === 1'b1) vs++;
            if (oFrame_Start === 1'b1) fs++;
            prev_h = oHREF;
        end
        sb_en = 1'b0;
        checks++; if (more != 1) begin errors++; $display("FAIL drop_lines_after: got %0d, required 1", more); end
        checks++; if (vs != 0 || fs != 0) begin errors++; $display("FAIL drop_new_frame: got vsync=%0d start=%0d, required 0 0", vs, fs); end
        checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL drop_missing: %0d bytes not seen, required 0", sb_q.size()); end
        checks++; if (oFrame_Count !== 8'd1) begin errors++; $display("FAIL drop_fcount: got %0d, required 1", oFrame_Count); end
    endtask

    task automatic test_async_reset();
        logic seen;
        int vs;
        do_reset();
        iMode = 2'd0;
        iEnable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge iCLK);
            if (oHREF === 1'b1 && oDATA !== 8'h00) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL arst_href_timeout: got no active data, required it within 300 iCLK"); end
        #2 iRST_N = 1'b0;
        #1;
        checks++; if ({oPCLK, oVSYNC, oHREF, oFrame_Start} !== 4'b0000) begin errors++; $display("FAIL arst_ctrl: got %b, required 0000", {oPCLK, oVSYNC, oHREF, oFrame_Start}); end
        checks++; if (oDATA !== 8'h00 || oFrame_Count !== 8'd0) begin errors++; $display("FAIL arst_data: got %02h/%0d, required 00/0", oDATA, oFrame_Count); end
        iEnable = 1'b0;
        repeat (5) @(negedge iCLK);
        checks++; if ({oPCLK, oVSYNC, oHREF} !== 3'b000) begin errors++; $display("FAIL arst_held: got %b, required 000", {oPCLK, oVSYNC, oHREF}); end
        iRST_N = 1'b1;
        vs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge iCLK);
            if (oVSYNC === 1'b1 || oHREF === 1'b1) vs++;
        end
        checks++; if (vs != 0) begin errors++; $display("FAIL arst_resume: got %0d active cycles, required 0", vs); end
    endtask

    task automatic test_frame_wrap();
        int fs, bad;
        logic wrapped;
        logic [7:0] prev;
        do_reset();
        iEnable = 1'b1;
        fs = 0; bad = 0; wrapped = 1'b0; prev = 8'd0;
        for (int i = 0; i < 72500 && !wrapped; i++) begin
            @(negedge iCLK);
            if (oFrame_Count !== prev) begin
                if (oFrame_Count !== prev + 8'd1) bad++;
                if (prev == 8'd255) wrapped = 1'b1;
                prev = oFrame_Count;
            end
            if (!wrapped && oFrame_Start === 1'b1) fs++;
        end
        iEnable = 1'b0;
        checks++; if (!wrapped || oFrame_Count !== 8'd0) begin errors++; $display("FAIL wrap_seen: got wrapped=%b count=%0d, required 1 0", wrapped, oFrame_Count); end
        checks++; if (fs != 256) begin errors++; $display("FAIL wrap_frames: got %0d frames, required 256", fs); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_steps: %0d bad increments, required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_line_structure();
        test_color_bars();
        test_frame_solid();
        test_mode_latch();
        test_enable_drop();
        test_async_reset();
        test_frame_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
